// File: rtl/npu_pkg.sv
// npu_pkg: shared state encoding, state type and default counter width for the layer scheduler
package npu_pkg;
  localparam int STATE_W = 4;
  localparam int CNT_W = 8;
  localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] S_CLEAR = 4'd1;
  localparam logic [STATE_W-1:0] S_MAC   = 4'd2;
  localparam logic [STATE_W-1:0] S_BIAS  = 4'd3;
  localparam logic [STATE_W-1:0] S_ACT   = 4'd4;
  localparam logic [STATE_W-1:0] S_PUSH  = 4'd5;
  localparam logic [STATE_W-1:0] S_DONE  = 4'd6;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR,
    ST_MAC   = S_MAC,
    ST_BIAS  = S_BIAS,
    ST_ACT   = S_ACT,
    ST_PUSH  = S_PUSH,
    ST_DONE  = S_DONE
  } state_t;
endpackage

// File: rtl/npu_run_counter.sv
// npu_run_counter: loadable up-counter (clk, rst, clr, load/d, en) with equality flag eq = (q == cmp)
module npu_run_counter
  import npu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic [W-1:0] cmp,
  output logic [W-1:0] q,
  output logic         eq
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (load) q <= d;
    else if (en) q <= q + 1'b1;
  assign eq = q == cmp;
endmodule

// File: rtl/npu_layer_sched.sv
// npu_layer_sched: per-neuron CLEAR/MAC/BIAS/ACT/PUSH sequencer; START/ABORT/counts in, datapath strobes, BUSY/DONE/STATE_DEBUG/OUT_CNT out
module npu_layer_sched
  import npu_pkg::*;
#(
  parameter int CNT_W = npu_pkg::CNT_W
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] NUM_BEATS,
  input  logic [CNT_W-1:0] NUM_OUT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FIFO_FULL,
  output logic             ACC_CLR,
  output logic             MAC_EN,
  output logic             BIAS_EN,
  output logic             ACT_EN,
  output logic             FIFO_WR,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       STATE_DEBUG,
  output logic [CNT_W-1:0] OUT_CNT
);
  state_t state, nxt;
  logic [CNT_W-1:0] nb, no, beat_unused;
  logic start_acc, beat_acc, last_beat, beat_eq, out_eq;
  assign start_acc = state == ST_IDLE && START && !ABORT;
  assign beat_acc = state == ST_MAC && IN_VALID;
  assign last_beat = beat_acc && beat_eq;
  always_ff @(posedge CLKEXT)
    if (RST_GLO) begin
      state <= ST_IDLE;
      nb <= '0;
      no <= '0;
    end else begin
      state <= nxt;
      if (start_acc) begin
        nb <= NUM_BEATS;
        no <= NUM_OUT;
      end
    end
  always_comb begin
    nxt = state;
    if (ABORT && state != ST_IDLE) nxt = ST_IDLE;
    else
      case (state)
        ST_IDLE:  if (start_acc) nxt = NUM_OUT == '0 ? ST_DONE : ST_CLEAR;
        ST_CLEAR: nxt = nb == '0 ? ST_BIAS : ST_MAC;
        ST_MAC:   if (last_beat) nxt = ST_BIAS;
        ST_BIAS:  nxt = ST_ACT;
        ST_ACT:   nxt = ST_PUSH;
        ST_PUSH:  if (!FIFO_FULL) nxt = out_eq ? ST_DONE : ST_CLEAR;
        ST_DONE:  nxt = ST_IDLE;
        default:  nxt = ST_IDLE;
      endcase
  end
  assign IN_READY = state == ST_MAC;
  assign MAC_EN = beat_acc;
  assign ACC_CLR = state == ST_CLEAR;
  assign BIAS_EN = state == ST_BIAS;
  assign ACT_EN = state == ST_ACT;
  // write is suppressed in a cycle that aborts or resets the run
  assign FIFO_WR = state == ST_PUSH && !FIFO_FULL && !ABORT && !RST_GLO;
  assign BUSY = state != ST_IDLE;
  assign DONE = state == ST_DONE;
  assign STATE_DEBUG = state;
  // last beat both clears and increments; clear wins so the next neuron restarts at 0
  npu_run_counter #(.W(CNT_W)) u_beat (
    .clk(CLKEXT), .rst(RST_GLO), .clr(start_acc || last_beat), .load(1'b0), .en(beat_acc),
    .d('0), .cmp(nb - 1'b1), .q(beat_unused), .eq(beat_eq)
  );
  npu_run_counter #(.W(CNT_W)) u_out (
    .clk(CLKEXT), .rst(RST_GLO), .clr(start_acc), .load(1'b0), .en(FIFO_WR),
    .d('0), .cmp(no - 1'b1), .q(OUT_CNT), .eq(out_eq)
  );
endmodule

// File: tb/tb_npu_layer_sched.sv
// tb_npu_layer_sched: directed literal scenarios plus randomized run against a behavioural model
module tb_npu_layer_sched;
  logic clk = 0, RST_GLO = 1, START = 0, ABORT = 0, IN_VALID = 0, FIFO_FULL = 0;
  logic [7:0] NUM_BEATS = 0, NUM_OUT = 0, OUT_CNT;
  logic IN_READY, ACC_CLR, MAC_EN, BIAS_EN, ACT_EN, FIFO_WR, BUSY, DONE;
  logic [3:0] STATE_DEBUG;
  int vectors = 0, errors = 0;
  bit chk = 0;
  always #5 clk = ~clk;
  npu_layer_sched dut (
    .CLKEXT(clk), .RST_GLO(RST_GLO), .START(START), .ABORT(ABORT), .NUM_BEATS(NUM_BEATS),
    .NUM_OUT(NUM_OUT), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FIFO_FULL(FIFO_FULL),
    .ACC_CLR(ACC_CLR), .MAC_EN(MAC_EN), .BIAS_EN(BIAS_EN), .ACT_EN(ACT_EN), .FIFO_WR(FIFO_WR),
    .BUSY(BUSY), .DONE(DONE), .STATE_DEBUG(STATE_DEBUG), .OUT_CNT(OUT_CNT)
  );
  // behavioural model: phase number, beats taken, neurons written, latched counts
  int ph = 0;
  logic [7:0] m_beat = 0, m_out = 0, m_nb = 0, m_no = 0;
  logic [19:0] act, exp_v;
  always @(negedge clk) if (chk) begin
    act = {IN_READY, ACC_CLR, MAC_EN, BIAS_EN, ACT_EN, FIFO_WR, BUSY, DONE, STATE_DEBUG, OUT_CNT};
    exp_v = {ph == 2, ph == 1, ph == 2 && IN_VALID, ph == 3, ph == 4,
             ph == 5 && !FIFO_FULL && !ABORT && !RST_GLO, ph != 0, ph == 6, 4'(ph), m_out};
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act, exp_v);
    end
    if (RST_GLO) begin
      ph = 0; m_beat = 0; m_out = 0;
    end else if (ABORT && ph != 0) ph = 0;
    else
      case (ph)
        0: if (START && !ABORT) begin
          m_nb = NUM_BEATS; m_no = NUM_OUT; m_beat = 0; m_out = 0;
          ph = m_no == 0 ? 6 : 1;
        end
        1: ph = m_nb == 0 ? 3 : 2;
        2: if (IN_VALID) begin
          m_beat++;
          if (m_beat == m_nb) begin m_beat = 0; ph = 3; end
        end
        3: ph = 4;
        4: ph = 5;
        5: if (!FIFO_FULL) begin m_out++; ph = m_out == m_no ? 6 : 1; end
        default: ph = 0;
      endcase
  end
  task automatic lit(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, a, e);
    end
  endtask
  int st[64], oc[64], wr_q[$], done_c, mac_n, strobe_n;
  // START at edge 0, then observe cycles 1..lim; per-cycle input shaping by cycle number
  task automatic run(input int no, nb, fa, fb, bub, spur, ab, rs, lim);
    NUM_OUT = 8'(no); NUM_BEATS = 8'(nb); START = 1; IN_VALID = 1; FIFO_FULL = 0; ABORT = 0;
    wr_q.delete(); done_c = 0; mac_n = 0; strobe_n = 0;
    @(posedge clk);
    for (int k = 1; k <= lim; k++) begin
      #1;
      START = k == spur;
      NUM_OUT = (spur > 0 && k >= spur) ? 8'd9 : 8'(no);
      NUM_BEATS = (spur > 0 && k >= spur) ? 8'd1 : 8'(nb);
      IN_VALID = bub ? k % 2 == 0 : 1'b1;
      FIFO_FULL = k >= fa && k <= fb;
      ABORT = k == ab;
      RST_GLO = k == rs;
      @(negedge clk);
      st[k] = STATE_DEBUG; oc[k] = OUT_CNT;
      if (DONE && done_c == 0) done_c = k;
      if (FIFO_WR) wr_q.push_back(k);
      mac_n += MAC_EN;
      strobe_n += ACC_CLR + MAC_EN + BIAS_EN + ACT_EN + FIFO_WR;
      @(posedge clk);
    end
    #1 START = 0; ABORT = 0; RST_GLO = 0; FIFO_FULL = 0;
  endtask
  initial begin
    @(posedge clk);
    #1 chk = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("reset_outputs", int'({IN_READY, ACC_CLR, MAC_EN, BIAS_EN, ACT_EN, FIFO_WR, BUSY, DONE, STATE_DEBUG, OUT_CNT}), 0);
    @(posedge clk);
    #1 RST_GLO = 0;
    run(2, 3, 0, 0, 0, 3, 0, 0, 17);
    lit("nom_done", done_c, 15);
    lit("nom_wr_n", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      lit("nom_wr0", wr_q[0], 7);
      lit("nom_wr1", wr_q[1], 14);
    end
    lit("nom_mac", mac_n, 6);
    lit("nom_outcnt", oc[16], 2);
    lit("nom_idle", st[16], 0);
    run(0, 2, 0, 0, 0, 0, 0, 0, 3);
    lit("zero_done", done_c, 1);
    lit("zero_strobes", strobe_n, 0);
    run(1, 0, 0, 0, 0, 0, 0, 0, 6);
    lit("bonly_seq", st[1] * 1000 + st[2] * 100 + st[3] * 10 + st[4], 1345);
    lit("bonly_done", done_c, 5);
    lit("bonly_mac", mac_n, 0);
    run(1, 2, 6, 10, 0, 0, 0, 0, 13);
    lit("bp_wr_n", wr_q.size(), 1);
    if (wr_q.size() == 1) lit("bp_wr", wr_q[0], 11);
    lit("bp_done", done_c, 12);
    run(1, 3, 0, 0, 1, 0, 0, 0, 11);
    lit("bub_mac", mac_n, 3);
    lit("bub_bias", st[7], 3);
    lit("bub_done", done_c, 10);
    run(3, 4, 0, 0, 0, 0, 4, 0, 7);
    lit("abort_idle", st[5], 0);
    lit("abort_done", done_c, 0);
    lit("abort_wr", wr_q.size(), 0);
    run(1, 1, 0, 0, 0, 0, 0, 5, 7);
    lit("rst_push", st[5], 5);
    lit("rst_wr", wr_q.size(), 0);
    lit("rst_idle", st[6], 0);
    lit("rst_outcnt", oc[6], 0);
    for (int i = 0; i < 3000; i++) begin
      START = $urandom % 6 == 0;
      ABORT = $urandom % 64 == 0;
      RST_GLO = $urandom % 300 == 0;
      IN_VALID = $urandom % 4 != 0;
      FIFO_FULL = $urandom % 4 == 0;
      NUM_OUT = 8'($urandom % 4);
      NUM_BEATS = 8'($urandom % 5);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/npu_layer_sched.md
# npu_layer_sched

Sequencing controller for the NPU MAC datapath. A single START pulse launches a run of NUM_OUT output neurons. For each neuron the block clears the accumulator, accepts NUM_BEATS four-lane input beats into the MAC, applies bias and activation, then pushes the result into the output FIFO under FIFO_FULL backpressure. It sits between the top-level control pins and the datapath/FIFO, and supplies BUSY, DONE and STATE_DEBUG to the top.

## Interface
- CNT_W, 8, width of beat/output counters and of NUM_BEATS/NUM_OUT

Ports:
- CLKEXT  in  1  clock; all logic on rising edge
- RST_GLO  in  1  reset, synchronous, active-high
- START  in  1  run request; sampled only in IDLE
- ABORT  in  1  cancel run; highest priority after reset
- NUM_BEATS  in  CNT_W  input beats per neuron; latched on accepted START
- NUM_OUT  in  CNT_W  neurons per run; latched on accepted START
- IN_VALID  in  1  upstream lanes DA..DD hold a valid beat
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY
- FIFO_FULL  in  1  output FIFO cannot accept a write
- ACC_CLR  out  1  clear accumulator
- MAC_EN  out  1  accumulate current beat
- BIAS_EN  out  1  add BIAS_IN to accumulator
- ACT_EN  out  1  apply activation and latch result
- FIFO_WR  out  1  write activated result to FIFO
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- STATE_DEBUG  out  4  current state encoding
- OUT_CNT  out  CNT_W  neurons completed in current run

## Operation
- States and encodings: IDLE=0, CLEAR=1, MAC=2, BIAS=3, ACT=4, PUSH=5, DONE=6. Codes 7–15 are unused; entering an unused code forces IDLE.
- IDLE: START=1 latches NUM_BEATS/NUM_OUT and zeroes beat_cnt and OUT_CNT. Next state is DONE if NUM_OUT==0, otherwise CLEAR.
- CLEAR: ACC_CLR=1. Next state is BIAS if latched NUM_BEATS==0 (bias-only neuron), otherwise MAC.
- MAC: IN_READY=1 and MAC_EN=IN_VALID. beat_cnt increments on each accepted beat. Acceptance of beat NUM_BEATS−1 moves to BIAS and clears beat_cnt. With IN_VALID=0 the block holds in MAC indefinitely.
- BIAS: BIAS_EN=1 for one cycle, then ACT.
- ACT: ACT_EN=1 for one cycle, then PUSH.
- PUSH: FIFO_WR=~FIFO_FULL. While FIFO_FULL=1 the block holds in PUSH with FIFO_WR=0. On a write, OUT_CNT increments; next state is DONE if OUT_CNT==NUM_OUT−1, otherwise CLEAR.
- DONE: DONE=1 for one cycle, then IDLE. OUT_CNT holds its final value until the next accepted START.
- START outside IDLE is ignored.
- ABORT=1 in any non-IDLE state: next state is IDLE, no DONE pulse, no FIFO_WR in that cycle, OUT_CNT keeps its value.
- Simultaneous START and ABORT in IDLE: ABORT wins and the block stays in IDLE.
- Counters wrap modulo 2^CNT_W, but no wrap is reachable because termination uses equality against the latched values.

## Timing
- Reset: RST_GLO=1 at a clock edge sets state=IDLE and clears the counters. All outputs are 0 on the following cycle; BUSY=0 and STATE_DEBUG=0.
- Reset mid-run: same result as above. No DONE pulse, and there is no FIFO_WR in the reset cycle.
- Decode style:
  - Strobes, BUSY, DONE and STATE_DEBUG are Moore outputs decoded from the registered state.
  - FIFO_WR is Mealy on FIFO_FULL, combinational in the same cycle.
  - MAC_EN is Mealy on IN_VALID.
- Edge numbering: START is sampled at edge 0; CLEAR occupies cycle 1.
- Per-neuron latency with no stalls: NUM_BEATS+4 cycles (CLEAR, N×MAC, BIAS, ACT, PUSH).
- DONE timing with no stalls: asserted in cycle NUM_OUT×(NUM_BEATS+4)+1. For NUM_OUT=0, DONE is asserted in cycle 1.
- Each IN_VALID-low cycle in MAC adds one cycle; each FIFO_FULL cycle in PUSH adds one cycle.
- BUSY falls in the cycle after DONE.

## Structure
- npu_pkg holds:
  - state localparams (S_IDLE..S_DONE, 4-bit)
  - STATE_W=4
  - default CNT_W
- The STATE_DEBUG encoding is shared with the top-level debug decode.
- One sub-module: npu_run_counter. It is a loadable up-counter with clear, enable and an equality flag, instantiated twice (beat_cnt, OUT_CNT).
- The FSM and output decode live in npu_layer_sched.

## Test plan
- Nominal run: NUM_OUT=2, NUM_BEATS=3, IN_VALID=1, FIFO_FULL=0, START at edge 0 -> MAC_EN high 3 cycles per neuron, FIFO_WR in cycles 7 and 14, DONE in cycle 15, OUT_CNT=2.
- Degenerate counts:
  - NUM_OUT=0 -> DONE in cycle 1, no strobes.
  - NUM_OUT=1, NUM_BEATS=0 -> CLEAR, BIAS, ACT, PUSH; DONE in cycle 5; MAC_EN never asserted.
- Backpressure: FIFO_FULL=1 for 5 cycles on entering PUSH (NUM_OUT=1, NUM_BEATS=2) -> FIFO_WR=0 for those 5 cycles, a single FIFO_WR on release, DONE 5 cycles later than nominal.
- Input bubbles: IN_VALID toggling 1,0,1,0,1 with NUM_BEATS=3 -> exactly 3 MAC_EN pulses, IN_READY high throughout MAC, BIAS entered after the third accepted beat.
- ABORT in MAC, plus START while BUSY -> ABORT returns to IDLE next cycle with no DONE/FIFO_WR; a START pulse issued mid-run is ignored (latched counts unchanged).
- RST_GLO asserted during PUSH with FIFO_FULL=0 -> no FIFO_WR that cycle; all outputs 0 and STATE_DEBUG=0 on the next cycle.
